// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding the 8-bit AXI-Stream TX input of the
// RGMII MAC from NUM_PORTS upstream frame sources.
//
// Ports:
//   clk, rst_n        125 MHz clock, asynchronous active-low reset
//   s_axis_*          per-port source streams (port i data at [8i+7:8i])
//   m_axis_*          merged stream to the MAC; tuser=1 marks an aborted/bad frame
//   grant             one-hot granted port, zero while idle
//   busy              high while a frame is being passed or drained
//   trunc_count       saturating count of frames cut at MAX_LEN bytes
//
// The data path is a zero-latency mux: m_axis_* and s_axis_tready are
// combinational functions of the registered grant/state.
module eth_tx_frame_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS*8-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    input  logic [NUM_PORTS-1:0]   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   busy,
    output logic [CNT_W-1:0]       trunc_count
);

    localparam int unsigned PW = $clog2(NUM_PORTS);
    localparam int unsigned LW = $clog2(MAX_LEN);
    localparam logic [LW-1:0] LAST_IDX = LW'(MAX_LEN - 1);
    localparam logic [PW-1:0] TOP_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        last_q, last_d;     // index of current/most recent grant
    logic [LW-1:0]        len_q, len_d;       // bytes forwarded in current frame
    logic [CNT_W-1:0]     trunc_q, trunc_d;

    logic [7:0]    sel_data;
    logic          sel_valid, sel_last, sel_user;
    logic          hi_found, lo_found;
    logic [PW-1:0] hi_idx, lo_idx, pick;
    logic          req_any;
    logic          in_pass, in_drain, at_max, pass_hs, force_trunc;

    // Granted-port view; last_q holds the granted index in PASS and DRAIN.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (last_q == PW'(i)) begin
                sel_data  = s_axis_tdata[i*8 +: 8];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    // Round-robin search: lowest requester above last_q wins, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                if (PW'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PW'(i);
                end
            end
        end
    end

    assign req_any     = hi_found | lo_found;
    assign pick        = hi_found ? hi_idx : lo_idx;
    assign in_pass     = (state_q == PASS);
    assign in_drain    = (state_q == DRAIN);
    assign at_max      = (len_q == LAST_IDX);
    assign pass_hs     = in_pass & sel_valid & m_axis_tready;
    assign force_trunc = in_pass & at_max & ~sel_last;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = NUM_PORTS'(1) << pick;
                    last_d  = pick;
                    len_d   = '0;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (pass_hs) begin
                    len_d = len_q + LW'(1);
                    if (sel_last) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else if (at_max) begin
                        if (trunc_q != '1) begin
                            trunc_d = trunc_q + CNT_W'(1);
                        end
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // tready is forced high here, so valid&last is the final handshake
                if (sel_valid && sel_last) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= TOP_PORT;
            len_q   <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

    // Output mux, gated by state so reset silences the MAC side immediately
    assign m_axis_tdata  = in_pass ? sel_data : 8'h00;
    assign m_axis_tvalid = in_pass & sel_valid;
    assign m_axis_tlast  = in_pass & (sel_last | at_max);
    assign m_axis_tuser  = in_pass & (sel_user | force_trunc);
    assign s_axis_tready = in_pass  ? (grant_q & {NUM_PORTS{m_axis_tready}}) :
                           in_drain ? grant_q : '0;
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign trunc_count   = trunc_q;

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
Frame-level round-robin arbiter that shares the single 8-bit AXI-Stream TX input of the 1G RGMII MAC between NUM_PORTS upstream frame sources, such as a loopback path and a CPU injection path.
- Grants one source at a time and holds the grant until that source's tlast handshake.
- Passes data through a zero-latency mux.
- Enforces a maximum frame length: oversize frames are truncated and marked bad via tuser, and the remainder of the source frame is drained.

Parameters:
NUM_PORTS, 2, number of requesting sources (2..8)
MAX_LEN, 1518, maximum bytes forwarded per frame before truncation (>=2)
CNT_W, 16, width of saturating truncation counter

Ports:
clk  in  1  system clock (125 MHz domain)
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_PORTS*8  per-port data, port i at [8i+7:8i]
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready
s_axis_tlast  in  NUM_PORTS  per-port end of frame
s_axis_tuser  in  NUM_PORTS  per-port bad-frame flag (sampled on tlast beat)
m_axis_tdata  out  8  to MAC TX
m_axis_tvalid  out  1  to MAC TX
m_axis_tready  in  1  from MAC TX
m_axis_tlast  out  1  to MAC TX
m_axis_tuser  out  1  to MAC TX, 1 = abort/bad frame
grant  out  NUM_PORTS  one-hot current grant, 0 when idle
busy  out  1  high in PASS or DRAIN
trunc_count  out  CNT_W  number of truncated frames, saturates at all-ones

Behaviour:
- Reset values (asynchronous on rst_n low): state=IDLE, grant=0, all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, byte count=0, trunc_count=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
- IDLE:
  - Among ports with s_axis_tvalid=1, pick the first one searching from last_grant+1 upward, modulo NUM_PORTS.
  - Register grant and last_grant, clear byte count, go to PASS.
  - One bubble cycle per arbitration.
  - No s_axis_tready is asserted in IDLE.
- PASS: pure combinational mux from the granted port.
  - m_axis_tdata/tvalid/tlast/tuser = granted s_axis_*.
  - s_axis_tready[g] = m_axis_tready; all other readies are 0.
  - Byte count increments on each m_axis handshake.
  - Handshake with tlast=1: go to IDLE and clear grant next cycle.
  - Handshake with tlast=0 while count==MAX_LEN-1 (the MAX_LEN-th byte): output that beat with m_axis_tlast=1 and m_axis_tuser=1 forced. Increment trunc_count (saturating), go to DRAIN.
  - A frame of exactly MAX_LEN bytes, with tlast on byte MAX_LEN, is not truncated and its tuser is passed through unchanged.
- DRAIN:
  - m_axis_tvalid=0; s_axis_tready[g]=1 regardless of m_axis_tready; source beats are discarded.
  - On the source's tlast handshake, go to IDLE.
- Grant never changes mid-frame. A requester deasserting tvalid mid-frame holds the grant, with m_axis_tvalid following the source.
- Simultaneous requests are served strictly alternately; no port is granted twice while another is waiting.
- AXIS stability: the arbiter never drops m_axis_tvalid without a handshake while in PASS, provided the source obeys AXIS.
- Reset mid-frame: everything returns to reset values immediately. The MAC sees tvalid drop without tlast, which is accepted as an abort.
- grant is one-hot or zero at all times; busy = (state != IDLE).

Test Plan:
- Port 0 only sends a 64-byte frame, m_axis_tready=1 -> 1 bubble cycle, then 64 bytes out in 64 cycles, tlast on byte 64, tuser=0, grant=01 then 00.
- Ports 0 and 1 each continuously offer 3 frames of 10 bytes -> output order P0,P1,P0,P1,P0,P1; one idle cycle between frames; no interleaving within a frame.
- Port 1 sends 20 bytes while m_axis_tready toggles 1,0,1,0 -> all 20 bytes delivered in order, data held stable while tready=0, port 0 ready stays 0.
- MAX_LEN=8, port 0 sends a 12-byte frame -> 8 bytes out, byte 8 with tlast=1 and tuser=1. Bytes 9-12 are drained with m_axis_tvalid=0; trunc_count=1; then port 1's pending frame is granted.
- MAX_LEN=8, 8-byte frame with s_axis_tuser=1 on tlast -> passed as-is, tuser=1, trunc_count unchanged (0).
- rst_n asserted low after byte 5 of a 30-byte frame -> same-cycle m_axis_tvalid=0, grant=0, tready=0. After release, the next request is arbitrated starting at port 0.
